// File: rtl/popcount25_expander.sv
// popcount25_expander: inverse of a 25-input popcount. Each accepted request
// produces a 25-bit word with exactly min(in_count, 25) ones, either packed
// into the low bits (thermometer) or rotated left by a pseudo-random amount.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready = 1
// BUILD  | shifting the thermometer pattern in, one bit per cycle (25 cycles)
// ROTATE | rotating the word left one bit per cycle, r cycles
// OUT    | result presented, held until out_ready
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   block idle and able to accept
//   in_count   requested number of ones (0..31, clamped to 25)
//   in_mode    0 = thermometer, 1 = rotated thermometer
//   out_valid  out_vec/out_sat valid
//   out_ready  consumer accepts result
//   out_vec    generated word (zero outside OUT)
//   out_sat    in_count was above 25 (zero outside OUT)
//   busy       not in IDLE
module popcount25_expander #(
  parameter logic [7:0] LFSR_SEED = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_count,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_vec,
  output logic        out_sat,
  output logic        busy
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUILD  = 2'd1,
    ROTATE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [24:0] vec;
  logic [4:0]  idx;
  logic [4:0]  rot_cnt;
  logic [4:0]  cnt;
  logic        sat;
  logic        mode;
  logic [7:0]  lfsr;

  logic        accept;
  logic        lfsr_fb;
  logic [4:0]  cnt_clamped;
  logic [4:0]  rot_raw;
  logic [4:0]  rot_new;
  logic [5:0]  build_thresh;
  logic        build_bit;

  assign accept      = in_valid && (state == IDLE);
  assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cnt_clamped = (in_count > 5'd25) ? 5'd25 : in_count;
  assign rot_raw     = (lfsr[4:0] >= 5'd25) ? (lfsr[4:0] - 5'd25) : lfsr[4:0];
  assign rot_new     = in_mode ? rot_raw : 5'd0;

  // Ones enter during the last cnt BUILD cycles so they land in bits [cnt-1:0].
  assign build_thresh = 6'd25 - {1'b0, cnt};
  assign build_bit    = ({1'b0, idx} >= build_thresh);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = BUILD;
      BUILD:  if (idx == 5'd24) state_nxt = (rot_cnt != 5'd0) ? ROTATE : OUT;
      ROTATE: if (rot_cnt == 5'd1) state_nxt = OUT;
      OUT:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec     <= 25'h0;
      idx     <= 5'd0;
      rot_cnt <= 5'd0;
      cnt     <= 5'd0;
      sat     <= 1'b0;
      mode    <= 1'b0;
      lfsr    <= SEED_EFF;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= cnt_clamped;
            sat     <= (in_count > 5'd25);
            mode    <= in_mode;
            vec     <= 25'h0;
            idx     <= 5'd0;
            rot_cnt <= rot_new;
            lfsr    <= {lfsr[6:0], lfsr_fb};
          end
        end
        BUILD: begin
          vec <= {vec[23:0], build_bit};
          idx <= idx + 5'd1;
        end
        ROTATE: begin
          vec     <= {vec[23:0], vec[24]};
          rot_cnt <= rot_cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign out_vec   = (state == OUT) ? vec : 25'h0;
  assign out_sat   = (state == OUT) ? sat : 1'b0;

endmodule

// File: tb/tb_popcount25_expander.sv
module tb_popcount25_expander;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_count;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_vec;
  logic        out_sat;
  logic        busy;

  int errors = 0;
  int checks = 0;

  popcount25_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus runs in the phase 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic accept(input logic [4:0] count, input logic mode);
    in_valid = 1'b1;
    in_count = count;
    in_mode  = mode;
    tick();
    in_valid = 1'b0;
    in_count = 5'd0;
    in_mode  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_case(input string name, input logic [4:0] count, input logic mode,
                          input int exp_lat, input logic [24:0] exp_vec, input logic exp_sat);
    int lat;
    accept(count, mode);
    wait_valid(lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_vec !== exp_vec) begin
      errors++;
      $display("FAIL %s out_vec: got %h expected %h", name, out_vec, exp_vec);
    end
    checks++;
    if (out_sat !== exp_sat) begin
      errors++;
      $display("FAIL %s out_sat: got %b expected %b", name, out_sat, exp_sat);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_vec !== 25'h0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b vld=%b vec=%h sat=%b expected 1 0 0 0 0",
               in_ready, busy, out_valid, out_vec, out_sat);
    end
  endtask

  task automatic test_thermometer();
    run_case("m0_c7",  5'd7,  1'b0, 25, 25'h000007F, 1'b0);
    run_case("m0_c0",  5'd0,  1'b0, 25, 25'h0000000, 1'b0);
    run_case("m0_c25", 5'd25, 1'b0, 25, 25'h1FFFFFF, 1'b0);
    run_case("m0_c31", 5'd31, 1'b0, 25, 25'h1FFFFFF, 1'b1);
    run_case("m0_c26", 5'd26, 1'b0, 25, 25'h1FFFFFF, 1'b1);
    run_case("m0_c1",  5'd1,  1'b0, 25, 25'h0000001, 1'b0);
  endtask

  // Seed 0x03: r = 3, lfsr -> 0x06; next r = 6, lfsr -> 0x0C; next r = 12.
  task automatic test_rotate();
    apply_reset();
    run_case("m1_first",  5'd4,  1'b1, 28, 25'h0000078, 1'b0);
    run_case("m1_second", 5'd4,  1'b1, 31, 25'h00003C0, 1'b0);
    run_case("m1_third",  5'd25, 1'b1, 37, 25'h1FFFFFF, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [24:0] held;
    out_ready = 1'b0;
    accept(5'd7, 1'b0);
    wait_valid(lat);
    held = out_vec;
    checks++;
    if (held !== 25'h000007F) begin
      errors++;
      $display("FAIL bp_initial_vec: got %h expected %h", held, 25'h000007F);
    end
    in_valid = 1'b1;
    in_count = 5'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_vec !== 25'h000007F || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vec=%h rdy=%b vld=%b expected 0000007f 0 1",
                 i, out_vec, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    in_count = 5'd0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== 25'h0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b vec=%h expected 1 0 0",
               in_ready, out_valid, out_vec);
    end
    // out_ready while idle must not matter
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle_ready: got rdy=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    accept(5'd9, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || out_vec !== 25'h0) begin
      errors++;
      $display("FAIL mid_build_outputs: got busy=%b vld=%b vec=%h expected 1 0 0",
               busy, out_valid, out_vec);
    end
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_vec !== 25'h0) begin
      errors++;
      $display("FAIL mid_reset_state: got rdy=%b busy=%b vld=%b vec=%h expected 1 0 0 0",
               in_ready, busy, out_valid, out_vec);
    end
    run_case("reseed_repeat", 5'd4, 1'b1, 28, 25'h0000078, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 5'd0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    tick();
    test_reset();
    test_thermometer();
    test_rotate();
    test_backpressure();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/popcount25_expander.md
POPCOUNT25_EXPANDER -- requirements
Module: popcount25_expander

Interface
REQ-001 Parameter LFSR_SEED, default 8'h03, is the reset value of the rotation LFSR; a value of 0 SHALL be replaced by 8'h01.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  request carries a count.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_count  input  5  target number of ones, 0..31.
REQ-007 in_mode  input  1  0 = thermometer; 1 = thermometer rotated by the pseudo-random amount.
REQ-008 out_valid  output  1  out_vec and out_sat are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_vec  output  25  generated word, the inverse of a 25-input popcount.
REQ-011 out_sat  output  1  in_count exceeded 25 and was clamped.
REQ-012 busy  output  1  state is not IDLE.

Function
REQ-013 The FSM SHALL have four states: IDLE, BUILD, ROTATE and OUT; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept occurs on an edge where in_valid=1 and in_ready=1. On accept the block SHALL:
- capture c = min(in_count, 25);
- set the sat flag to 1 if in_count > 25, else 0;
- capture in_mode;
- clear vec and idx;
- go to BUILD.
REQ-015 On accept the block SHALL also capture r:
- r = lfsr[4:0], minus 25 if that value is >= 25;
- r = 0 when in_mode = 0.
REQ-016 On accept the LFSR SHALL advance one step: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, with the feedback bit entering bit 0. The LFSR SHALL NOT advance at any other time.
REQ-017 BUILD step, on each edge:
- vec <= {vec[23:0], b}, where b = 1 iff idx >= 25-c;
- idx increments.
REQ-018 After exactly 25 BUILD edges (idx = 24 on the final one), vec SHALL hold ones in bits [c-1:0] and zeros elsewhere. The next state SHALL be ROTATE if r != 0, else OUT.
REQ-019 ROTATE step, on each edge:
- vec <= {vec[23:0], vec[24]} (rotate left by one);
- the remaining count decrements.
After r edges the next state SHALL be OUT.
REQ-020 Latency: out_valid SHALL first be 1 exactly 25+r cycles after the accept edge; in mode 0 this is 25 cycles.
REQ-021 In OUT, out_valid SHALL be 1. While out_ready = 0, out_vec and out_sat SHALL hold stable.
REQ-022 An edge in OUT with out_ready = 1 SHALL return the FSM to IDLE. A new accept is possible at the earliest on the following edge, with no same-cycle pass-through.
REQ-023 Outside OUT:
- out_vec SHALL be 25'h0;
- out_sat SHALL be 0;
- out_valid SHALL be 0.
REQ-024 in_count, in_mode and in_valid SHALL be ignored outside IDLE.
REQ-025 The population count of out_vec SHALL always equal c, in every mode and for every r.
REQ-026 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-027 An edge with rst_n = 0 SHALL set:
- state = IDLE;
- vec = 0, idx = 0, and the remaining rotate count = 0;
- the sat flag = 0;
- lfsr = LFSR_SEED (or 8'h01 if the seed is 0).
REQ-028 Reset in any state, including mid-BUILD or mid-ROTATE, SHALL abandon the transaction. The cycle after the reset edge SHALL show out_valid = 0, in_ready = 1 and busy = 0.

Verification
REQ-029 Mode 0, in_count = 7 -> out_valid 25 cycles after accept, out_vec = 25'h000007F, out_sat = 0.
REQ-030 Mode 0, in_count = 0 -> out_vec = 25'h0. Mode 0, in_count = 25 -> out_vec = 25'h1FFFFFF, out_sat = 0.
REQ-031 Mode 0, in_count = 31 -> out_vec = 25'h1FFFFFF, out_sat = 1.
REQ-032 Default seed, first transaction mode 1, in_count = 4 -> r = 3, out_valid at 28 cycles after accept, out_vec = 25'h0000078.
REQ-033 Backpressure: hold out_ready = 0 for 10 cycles in OUT -> out_vec stable and in_ready = 0; pulse out_ready -> IDLE on the next edge, in_ready = 1.
REQ-034 Reset mid-flight: assert rst_n = 0 at BUILD idx = 12 -> next cycle IDLE with out_vec = 0. Then repeat the REQ-032 stimulus -> identical result, proving the LFSR was re-seeded.
